// File: rtl/ca4_top.sv
// Serial frame receiver/forwarder: start bit, LEN_W-bit length (MSB first),
// then the payload bits are forwarded to SerOut one clock late.
module ca4_top #(
  parameter int LEN_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic SerIn,
  output logic SerOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LAST_LEN_BIT = LEN_W'(LEN_W - 1);
  localparam logic [LEN_W-1:0] ONE          = LEN_W'(1);

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_serout;

  // Length value including the bit being sampled this cycle.
  logic [LEN_W-1:0] w_len_next;
  assign w_len_next = {r_len[LEN_W-2:0], SerIn};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_cnt    <= '0;
      r_serout <= 1'b0;
    end else begin
      r_serout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!SerIn) begin
            r_state <= LEN;
            r_cnt   <= '0;
          end
        end
        LEN: begin
          r_len <= w_len_next;
          if (r_cnt == LAST_LEN_BIT) begin
            r_cnt   <= '0;
            r_state <= (w_len_next == '0) ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        DATA: begin
          // Payload is copied verbatim; a 0 here never restarts framing.
          r_serout <= SerIn;
          if (r_cnt == r_len - ONE) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign SerOut = r_serout;

endmodule

// File: tb/tb_ca4_top.sv
// Scoreboard bench for ca4_top: expected SerOut per driven bit is queued from
// the frame structure and compared against the sampled output.
module tb_ca4_top;

  logic clk;
  logic rst;
  logic SerIn;
  logic SerOut;

  int checks;
  int failures;

  logic exp_q[$];
  logic obs_q[$];

  ca4_top #(.LEN_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .SerIn (SerIn),
    .SerOut(SerOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Drive one bit between edges; record what SerOut should be after the edge.
  task automatic drive_bit(input logic b, input logic e);
    @(negedge clk);
    SerIn = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs_q.push_back(SerOut);
  endtask

  task automatic send_frame(input int n, input logic [14:0] p);
    logic [3:0] nl;
    nl = 4'(n);
    drive_bit(1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) drive_bit(nl[i], 1'b0);
    for (int i = n - 1; i >= 0; i--) drive_bit(p[i], p[i]);
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    SerIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      SerIn = ~SerIn;
      @(posedge clk);
      #1;
      checks++;
      if (SerOut !== 1'b0) begin
        failures++;
        $display("FAIL reset_serout cycle %0d: got %b want 0", i, SerOut);
      end
      checks++;
      if (2'(dut.r_state) !== 2'd0 || dut.r_cnt !== 4'd0 || dut.r_len !== 4'd0) begin
        failures++;
        $display("FAIL reset_regs cycle %0d: state=%0d cnt=%0d len=%0d want 0/0/0",
                 i, dut.r_state, dut.r_cnt, dut.r_len);
      end
    end
    @(negedge clk);
    SerIn = 1'b1;
    rst   = 1'b1;
  endtask

  task automatic test_max_frame();
    logic e, o;
    drive_bit(1'b1, 1'b0);
    send_frame(15, 15'b101110000010101);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL max_frame bit %0d: got %b want %b", i, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e, o;
    send_frame(10, 15'b000000001111101);
    drive_bit(1'b1, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL back_to_back bit %0d: got %b want %b", i, o, e);
      end
    end
    checks++;
    if (2'(dut.r_state) !== 2'd0) begin
      failures++;
      $display("FAIL back_to_back_idle: state=%0d want 0", dut.r_state);
    end
  endtask

  task automatic test_zero_length();
    logic e, o;
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    send_frame(0, 15'd0);
    checks++;
    if (2'(dut.r_state) !== 2'd0) begin
      failures++;
      $display("FAIL zero_len_idle: state=%0d want 0", dut.r_state);
    end
    drive_bit(1'b1, 1'b0);
    // Empty frame followed immediately by a start bit.
    send_frame(0, 15'd0);
    send_frame(1, 15'd1);
    drive_bit(1'b1, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL zero_length bit %0d: got %b want %b", i, o, e);
      end
    end
  endtask

  task automatic test_framing();
    logic e, o;
    send_frame(3, 15'b000);
    drive_bit(1'b1, 1'b0);
    checks++;
    if (2'(dut.r_state) !== 2'd0) begin
      failures++;
      $display("FAIL framing_idle: state=%0d want 0", dut.r_state);
    end
    drive_bit(1'b1, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL framing bit %0d: got %b want %b", i, o, e);
      end
    end
  endtask

  task automatic test_len_one();
    logic e, o;
    send_frame(1, 15'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL len_one bit %0d: got %b want %b", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_payload();
    logic e, o;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mid_reset_pre bit %0d: got %b want %b", i, o, e);
      end
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (SerOut !== 1'b0 || 2'(dut.r_state) !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset_async: serout=%b state=%0d want 0/0", SerOut, dut.r_state);
    end
    SerIn = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (SerOut !== 1'b0 || 2'(dut.r_state) !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset_hold: serout=%b state=%0d want 0/0", SerOut, dut.r_state);
    end
    @(negedge clk);
    SerIn = 1'b1;
    rst   = 1'b1;
    send_frame(2, 15'b11);
    drive_bit(1'b1, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mid_reset_post bit %0d: got %b want %b", i, o, e);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    SerIn    = 1'b1;
    test_reset();
    test_max_frame();
    test_back_to_back();
    test_zero_length();
    test_framing();
    test_len_one();
    test_reset_mid_payload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
